// File: rtl/bmm150_pkg.sv
`default_nettype none
// ==== bmm150_pkg : register map, FSM encoding and sample record for the BMM150 sequencer == Rev 1.0 ====
package bmm150_pkg;

   localparam logic [6:0] REG_CHIP_ID    = 7'h40;
   localparam logic [6:0] REG_DATA_X_LSB = 7'h42;
   localparam logic [6:0] REG_PWR_CTRL   = 7'h4B;
   localparam logic [6:0] REG_OP_MODE    = 7'h4C;

   typedef logic [3:0] state_t;

   localparam state_t ST_OFF      = 4'd0;
   localparam state_t ST_PWR      = 4'd1;
   localparam state_t ST_WAIT_UP  = 4'd2;
   localparam state_t ST_RD_ID    = 4'd3;
   localparam state_t ST_SET_MODE = 4'd4;
   localparam state_t ST_SAMPLE   = 4'd5;
   localparam state_t ST_BURST    = 4'd6;
   localparam state_t ST_UNPACK   = 4'd7;
   localparam state_t ST_ERROR    = 4'd8;

   typedef struct packed {
      logic signed [12:0] x;
      logic signed [12:0] y;
      logic signed [14:0] z;
      logic        [13:0] rhall;
      logic               drdy;
   } mag_sample_t;

endpackage
`default_nettype wire

// File: rtl/bmm150_ctrl_if.sv
`default_nettype none
// ==== bmm150_ctrl_if : start/done handshake to the BMM150 SPI master ==== Rev 1.0 ====
interface bmm150_ctrl_if;
   logic        spi_enable;
   logic        spi_start;
   logic        spi_burst;
   logic        spi_rw;
   logic [6:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic [7:0]  spi_rdata;
   logic [63:0] spi_bdata;
   logic        spi_busy;
   logic        spi_done;

   modport master (
      output spi_enable, spi_start, spi_burst, spi_rw, spi_addr, spi_wdata,
      input  spi_rdata, spi_bdata, spi_busy, spi_done
   );

   modport slave (
      input  spi_enable, spi_start, spi_burst, spi_rw, spi_addr, spi_wdata,
      output spi_rdata, spi_bdata, spi_busy, spi_done
   );
endinterface
`default_nettype wire

// File: rtl/bmm150_unpack.sv
`default_nettype none
// ==== bmm150_unpack : splits a 0x42..0x49 burst into X/Y/Z/RHALL/DRDY ==== Rev 1.0 ====
module bmm150_unpack
   import bmm150_pkg::*;
(
   input  wire logic [63:0] bdata,
   output mag_sample_t      sample
);
   // Byte 0x42 sits in the top lane; the LSB registers carry the low bits left-justified.
   logic w_unused;

   always_comb begin
      sample.x     = {bdata[55:48], bdata[63:59]};
      sample.y     = {bdata[39:32], bdata[47:43]};
      sample.z     = {bdata[23:16], bdata[31:25]};
      sample.rhall = {bdata[7:0],   bdata[15:10]};
      sample.drdy  = bdata[8];
   end

   assign w_unused = ^{bdata[58:56], bdata[42:40], bdata[24], bdata[9]};
endmodule
`default_nettype wire

// File: rtl/bmm150_ctrl.sv
`default_nettype none
// ==== bmm150_ctrl : BMM150 power-up/config sequencer with periodic 8-byte burst reads ==== Rev 1.0 ====
module bmm150_ctrl
   import bmm150_pkg::*;
#(
   parameter int         CLK_HZ      = 50_000_000,
   parameter int         SAMPLE_HZ   = 10,
   parameter int         STARTUP_US  = 3000,
   parameter logic [7:0] CHIP_ID     = 8'h32,
   parameter int         TIMEOUT_CYC = 4096
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          enable,
   bmm150_ctrl_if.master      spi,
   output logic signed [12:0] mag_x,
   output logic signed [12:0] mag_y,
   output logic signed [14:0] mag_z,
   output logic        [13:0] rhall,
   output logic               drdy,
   output logic               data_valid,
   output logic               init_done,
   output logic               err
);
   localparam logic [31:0] c_STARTUP_CYC = 32'((64'(STARTUP_US) * 64'(CLK_HZ)) / 64'd1_000_000);
   localparam logic [31:0] c_PERIOD_M1   = 32'(CLK_HZ / SAMPLE_HZ - 1);
   localparam int          c_TO_W        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYC);

   state_t            r_state;
   logic              r_issued, r_start, r_burst, r_rw;
   logic [6:0]        r_addr;
   logic [7:0]        r_wdata;
   logic [31:0]       r_timer;
   logic [c_TO_W-1:0] r_to_cnt;
   logic [63:0]       r_bdata;
   mag_sample_t       r_sample, w_unpacked;
   logic              r_valid, r_init_done, r_err;
   logic              w_xfer, w_launch, w_done, w_timeout;
   logic              w_cmd_burst, w_cmd_rw;
   logic [6:0]        w_cmd_addr;
   logic [7:0]        w_cmd_wdata;
   logic [31:0]       w_timer_dec;

   bmm150_unpack u_unpack (.bdata(r_bdata), .sample(w_unpacked));

   always_comb begin
      w_xfer      = 1'b1;
      w_cmd_burst = 1'b0;
      w_cmd_rw    = 1'b0;
      w_cmd_addr  = '0;
      w_cmd_wdata = '0;
      case (r_state)
         ST_PWR:      begin w_cmd_addr = REG_PWR_CTRL; w_cmd_wdata = 8'h01; end
         ST_RD_ID:    begin w_cmd_addr = REG_CHIP_ID;  w_cmd_rw = 1'b1; end
         ST_SET_MODE: begin w_cmd_addr = REG_OP_MODE;  w_cmd_wdata = 8'h00; end
         ST_BURST:    begin w_cmd_addr = REG_DATA_X_LSB; w_cmd_rw = 1'b1; w_cmd_burst = 1'b1; end
         default:     w_xfer = 1'b0;
      endcase
   end

   // Launch needs the master fully idle, which also enforces the one-cycle gap after done.
   assign w_launch    = w_xfer && !r_issued && !spi.spi_busy && !spi.spi_done;
   assign w_done      = w_xfer && r_issued && spi.spi_done;
   assign w_timeout   = w_xfer && r_issued && !spi.spi_done && (r_to_cnt == c_TO_MAX);
   assign w_timer_dec = (r_timer == 32'd0) ? 32'd0 : r_timer - 32'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_OFF;
         r_issued    <= 1'b0;
         r_start     <= 1'b0;
         r_burst     <= 1'b0;
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_timer     <= '0;
         r_to_cnt    <= '0;
         r_bdata     <= '0;
         r_sample    <= '0;
         r_valid     <= 1'b0;
         r_init_done <= 1'b0;
         r_err       <= 1'b0;
      end else if (!enable) begin
         // Sample registers deliberately keep their last values.
         r_state     <= ST_OFF;
         r_issued    <= 1'b0;
         r_start     <= 1'b0;
         r_burst     <= 1'b0;
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_timer     <= '0;
         r_to_cnt    <= '0;
         r_valid     <= 1'b0;
         r_init_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_valid <= 1'b0;
         if (w_launch) begin
            r_start  <= 1'b1;
            r_issued <= 1'b1;
            r_to_cnt <= '0;
            r_burst  <= w_cmd_burst;
            r_rw     <= w_cmd_rw;
            r_addr   <= w_cmd_addr;
            r_wdata  <= w_cmd_wdata;
         end else if (r_issued) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         if (w_done) r_issued <= 1'b0;

         case (r_state)
            ST_OFF: r_state <= ST_PWR;
            ST_PWR: if (w_done) begin
               r_state <= ST_WAIT_UP;
               r_timer <= c_STARTUP_CYC;
            end
            ST_WAIT_UP: begin
               if (r_timer == 32'd0) r_state <= ST_RD_ID;
               else                  r_timer <= w_timer_dec;
            end
            ST_RD_ID: if (w_done) begin
               if (spi.spi_rdata == CHIP_ID) begin
                  r_state <= ST_SET_MODE;
               end else begin
                  r_state <= ST_ERROR;
                  r_err   <= 1'b1;
               end
            end
            ST_SET_MODE: if (w_done) begin
               r_state     <= ST_SAMPLE;
               r_init_done <= 1'b1;
               r_timer     <= '0;
            end
            ST_SAMPLE: begin
               if (r_timer == 32'd0) begin
                  r_state <= ST_BURST;
                  r_timer <= c_PERIOD_M1;
               end else begin
                  r_timer <= w_timer_dec;
               end
            end
            // The sample timer keeps running here so the burst period stays exact.
            ST_BURST: begin
               r_timer <= w_timer_dec;
               if (w_done) begin
                  r_state <= ST_UNPACK;
                  r_bdata <= spi.spi_bdata;
               end
            end
            ST_UNPACK: begin
               r_timer  <= w_timer_dec;
               r_sample <= w_unpacked;
               r_valid  <= 1'b1;
               r_state  <= ST_SAMPLE;
            end
            default: r_state <= ST_ERROR;
         endcase

         if (w_timeout) begin
            r_state     <= ST_ERROR;
            r_err       <= 1'b1;
            r_init_done <= 1'b0;
            r_issued    <= 1'b0;
         end
      end
   end

   assign spi.spi_enable = enable;
   assign spi.spi_start  = r_start;
   assign spi.spi_burst  = r_burst;
   assign spi.spi_rw     = r_rw;
   assign spi.spi_addr   = r_addr;
   assign spi.spi_wdata  = r_wdata;

   assign mag_x      = r_sample.x;
   assign mag_y      = r_sample.y;
   assign mag_z      = r_sample.z;
   assign rhall      = r_sample.rhall;
   assign drdy       = r_sample.drdy;
   assign data_valid = r_valid;
   assign init_done  = r_init_done;
   assign err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bmm150_ctrl.sv
`default_nettype none
// ==== tb_bmm150_ctrl : randomized bench with a behavioural SPI slave and sample reference model ==== Rev 1.0 ====
module tb_bmm150_ctrl;
   localparam int         CLK_HZ      = 50_000_000;
   localparam int         SAMPLE_HZ   = 25_000;
   localparam int         STARTUP_US  = 10;
   localparam logic [7:0] CHIP_ID     = 8'h32;
   localparam int         TIMEOUT_CYC = 4096;
   localparam int         PERIOD      = CLK_HZ / SAMPLE_HZ;
   localparam int         STARTUP     = STARTUP_US * (CLK_HZ / 1_000_000);

   logic clk = 1'b0;
   logic rst_n, enable;
   logic signed [12:0] mag_x, mag_y;
   logic signed [14:0] mag_z;
   logic [13:0] rhall;
   logic drdy, data_valid, init_done, err;

   bmm150_ctrl_if spi ();

   bmm150_ctrl #(
      .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .STARTUP_US(STARTUP_US),
      .CHIP_ID(CHIP_ID), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .spi(spi),
      .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z), .rhall(rhall), .drdy(drdy),
      .data_valid(data_valid), .init_done(init_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic       burst;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
   } txn_t;

   txn_t        log_q[$];
   int          burst_t[$];
   logic [63:0] bq[$];
   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_valid  = 0;
   int          last_x = 0, last_y = 0, last_z = 0, last_rh = 0, last_dr = 0;
   int          cyc = 0;
   int          cnt = 0;
   int          lat;
   bit          hang = 1'b0;
   logic [7:0]  id_val;
   logic [6:0]  cur_addr;
   logic        cur_burst;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Each register is a 16-bit little-endian word, right-justified by its unused LSBs.
   function automatic void ref_unpack(input logic [63:0] b, output int x, output int y,
                                      output int z, output int rh, output int dr);
      logic [7:0] by [0:7];
      logic signed [15:0] w;
      for (int i = 0; i < 8; i++) by[i] = b[63-8*i -: 8];
      w = {by[1], by[0]}; x = int'(w) >>> 3;
      w = {by[3], by[2]}; y = int'(w) >>> 3;
      w = {by[5], by[4]}; z = int'(w) >>> 1;
      rh = int'({by[7], by[6]}) >> 2;
      dr = int'(by[6][0]);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n || !spi.spi_enable) begin
         spi.spi_busy  <= 1'b0;
         spi.spi_done  <= 1'b0;
         spi.spi_rdata <= '0;
         spi.spi_bdata <= '0;
         cnt           <= 0;
      end else begin
         spi.spi_done <= 1'b0;
         if (spi.spi_start) begin
            if (spi.spi_busy || spi.spi_done)
               check_eq("start_when_busy", 64'({spi.spi_busy, spi.spi_done}), 64'd0);
            log_q.push_back('{cyc, spi.spi_burst, spi.spi_rw, spi.spi_addr, spi.spi_wdata});
            if (spi.spi_burst) burst_t.push_back(cyc);
            cur_addr     <= spi.spi_addr;
            cur_burst    <= spi.spi_burst;
            spi.spi_busy <= 1'b1;
            cnt          <= lat;
         end else if (spi.spi_busy) begin
            if (spi.spi_addr != cur_addr) check_eq("addr_hold", 64'(spi.spi_addr), 64'(cur_addr));
            if (!hang) begin
               if (cnt == 0) begin
                  spi.spi_busy  <= 1'b0;
                  spi.spi_done  <= 1'b1;
                  spi.spi_rdata <= id_val;
                  if (cur_burst && bq.size() > 0) begin
                     spi.spi_bdata <= bq[0];
                     exp_q.push_back(bq[0]);
                     void'(bq.pop_front());
                  end
               end else begin
                  cnt <= cnt - 1;
               end
            end
         end
      end
   end

   initial begin : monitor
      int ex, ey, ez, erh, edr;
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && data_valid) begin
            check_eq("valid_pulse", 64'(prev_valid), 64'd0);
            if (exp_q.size() == 0) begin
               check_eq("valid_no_burst", 64'(exp_q.size()), 64'd1);
            end else begin
               ref_unpack(exp_q[0], ex, ey, ez, erh, edr);
               void'(exp_q.pop_front());
               check_eq("mag_x", 64'($signed(mag_x)), 64'(ex));
               check_eq("mag_y", 64'($signed(mag_y)), 64'(ey));
               check_eq("mag_z", 64'($signed(mag_z)), 64'(ez));
               check_eq("rhall", 64'(rhall), 64'(erh));
               check_eq("drdy",  64'(drdy),  64'(edr));
               last_x = ex; last_y = ey; last_z = ez; last_rh = erh; last_dr = edr;
            end
            n_valid++;
         end
         prev_valid = data_valid;
      end
   end

   task automatic check_txn(input string tag, input int idx, input logic [16:0] exp);
      if (idx < log_q.size())
         check_eq(tag, 64'({log_q[idx].burst, log_q[idx].rw, log_q[idx].addr, log_q[idx].wdata}), 64'(exp));
      else
         check_eq({tag, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
   endtask

   task automatic wait_for_init(input string tag);
      int n = 0;
      while (!init_done && n < 3000) begin @(negedge clk); n++; end
      check_eq(tag, 64'(init_done), 64'd1);
   endtask

   task automatic wait_burst_start(input string tag);
      int n = 0;
      while (!(spi.spi_start && spi.spi_burst) && n < 3000) begin @(negedge clk); n++; end
      check_eq(tag, 64'(spi.spi_start && spi.spi_burst), 64'd1);
   endtask

   task automatic check_data_kept(input string tag);
      check_eq({tag, "_x"}, 64'($signed(mag_x)), 64'(last_x));
      check_eq({tag, "_z"}, 64'($signed(mag_z)), 64'(last_z));
      check_eq({tag, "_rh"}, 64'(rhall), 64'(last_rh));
   endtask

   initial begin : main
      int nv, ns, n, gap;
      rst_n  = 1'b0;
      enable = 1'b0;
      id_val = CHIP_ID;
      lat    = 3 + int'($urandom_range(0, 5));
      bq.push_back(64'hF8FF_0800_0200_0500);
      for (int i = 0; i < 40; i++) bq.push_back({$urandom, $urandom});

      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", 64'({spi.spi_start, spi.spi_burst, spi.spi_rw, spi.spi_addr, spi.spi_wdata,
                                data_valid, init_done, err, spi.spi_enable}), 64'd0);
      check_eq("rst_data", 64'({mag_x, mag_y, mag_z, rhall, drdy}), 64'd0);

      // Power-up and configuration
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_for_init("init1");
      check_txn("txn_pwr", 0, {1'b0, 1'b0, 7'h4B, 8'h01});
      check_txn("txn_id",  1, {1'b0, 1'b1, 7'h40, 8'h00});
      check_txn("txn_mode", 2, {1'b0, 1'b0, 7'h4C, 8'h00});
      if (log_q.size() >= 2) begin
         gap = log_q[1].t - log_q[0].t;
         check_eq("startup_gap", 64'(gap >= STARTUP + lat && gap <= STARTUP + lat + 8), 64'd1);
      end
      check_eq("err_after_init", 64'(err), 64'd0);

      // Steady sampling: first burst is the directed pattern, the rest random
      nv = n_valid;
      n = 0;
      while (n_valid < nv + 5 && n < 6 * PERIOD) begin @(negedge clk); n++; end
      check_eq("n_valid5", 64'(n_valid - nv), 64'd5);
      for (int i = 0; i < 4; i++)
         if (i + 1 < burst_t.size())
            check_eq($sformatf("period%0d", i), 64'(burst_t[i+1] - burst_t[i]), 64'(PERIOD));

      // Slave hangs: timeout must fire exactly after TIMEOUT_CYC cycles
      hang = 1'b1;
      wait_burst_start("to_start");
      repeat (TIMEOUT_CYC) @(negedge clk);
      check_eq("err_before_to", 64'(err), 64'd0);
      @(negedge clk);
      check_eq("err_at_to", 64'(err), 64'd1);
      check_eq("init_at_to", 64'(init_done), 64'd0);
      hang = 1'b0;
      ns = log_q.size();
      repeat (PERIOD + 500) @(negedge clk);
      check_eq("no_start_in_err", 64'(log_q.size()), 64'(ns));
      check_eq("err_sticky", 64'(err), 64'd1);

      // enable low clears the error but keeps data
      enable = 1'b0;
      @(negedge clk);
      exp_q.delete();
      check_eq("err_cleared", 64'({err, init_done, spi.spi_enable}), 64'd0);
      check_data_kept("keep_off");

      // Wrong chip ID
      id_val = 8'h31;
      log_q.delete();
      enable = 1'b1;
      n = 0;
      while (!err && n < 3000) begin @(negedge clk); n++; end
      check_eq("err_bad_id", 64'(err), 64'd1);
      check_eq("init_bad_id", 64'(init_done), 64'd0);
      repeat (500) @(negedge clk);
      check_eq("bad_id_txns", 64'(log_q.size()), 64'd2);
      check_txn("bad_id_rd", 1, {1'b0, 1'b1, 7'h40, 8'h00});

      // Restart from PWR after toggling enable
      enable = 1'b0;
      @(negedge clk);
      id_val = CHIP_ID;
      log_q.delete();
      enable = 1'b1;
      wait_for_init("init_restart");
      check_txn("restart_pwr", 0, {1'b0, 1'b0, 7'h4B, 8'h01});

      // enable drops mid-burst
      wait_burst_start("burst_a");
      enable = 1'b0;
      @(negedge clk);
      check_eq("off_ctrl", 64'({spi.spi_start, init_done, err, spi.spi_enable}), 64'd0);
      check_data_kept("keep_burst");
      repeat (20) @(negedge clk);
      log_q.delete();
      enable = 1'b1;
      wait_for_init("init_reenable");
      check_txn("reenable_pwr", 0, {1'b0, 1'b0, 7'h4B, 8'h01});

      // Reset mid-burst
      wait_burst_start("burst_b");
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_ctrl", 64'({spi.spi_start, spi.spi_addr, data_valid, init_done, err}), 64'd0);
      check_eq("rst_mid_data", 64'({mag_x, mag_y, mag_z, rhall, drdy}), 64'd0);
      rst_n = 1'b1;
      wait_for_init("init_after_rst");
      nv = n_valid;
      n = 0;
      while (n_valid == nv && n < 2 * PERIOD) begin @(negedge clk); n++; end
      check_eq("valid_after_rst", 64'(n_valid > nv), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
